// File: rtl/compress_return_pkg.sv
// Shared types and constants for the multi-channel return packer.
package compress_return_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    LAST  = 2'd2
  } state_t;

  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_IN_BYTES     = 16;
  localparam int DEF_OUT_BYTES    = 8;
  localparam int DEF_BUF_BYTES    = 64;

  // Width needed to hold a byte count in the range 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: searches upward from the channel after the last grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int c = 0; c < N; c++) begin
        if (!grant_valid && req[c] && (((int'(last_grant) + k) % N) == c)) begin
          grant[c]    = 1'b1;
          grant_idx   = IW'(c);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_channel_return_packer.sv
// Packs variable-length channel segments into fixed-width output words,
// with an end-of-stream flush that emits a final partial word marked last.
module multi_channel_return_packer
  import compress_return_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int IN_BYTES     = DEF_IN_BYTES,
  parameter int OUT_BYTES    = DEF_OUT_BYTES,
  parameter int BUF_BYTES    = DEF_BUF_BYTES
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_CHANNELS*IN_BYTES*8-1:0]          inData,
  input  logic [NUM_CHANNELS*count_width(IN_BYTES)-1:0] inByteCount,
  output logic [NUM_CHANNELS-1:0]                     inTaken,
  input  logic                                        endOfStream,
  output logic [OUT_BYTES*8-1:0]                      dataOut,
  output logic [count_width(OUT_BYTES)-1:0]           dataOutBytes,
  output logic                                        dataOutValid,
  input  logic                                        dataOutReady,
  output logic                                        dataOutLast,
  output logic                                        busy
);

  localparam int CW = count_width(IN_BYTES);
  localparam int OW = count_width(OUT_BYTES);
  localparam int FW = count_width(BUF_BYTES);
  localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  if (BUF_BYTES < IN_BYTES + OUT_BYTES) begin : g_bad_buf_size
    $error("BUF_BYTES must be at least IN_BYTES + OUT_BYTES");
  end

  state_t            state_q, state_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [IW-1:0]     last_grant_q;
  logic [7:0]        buf_q [BUF_BYTES];
  logic [7:0]        buf_d [BUF_BYTES];

  logic              out_valid, out_last;
  logic [OW-1:0]     out_bytes;
  logic              pop;
  logic [FW-1:0]     pop_bytes, fill_after, free_after;
  logic              grant_allowed;

  logic [CW-1:0]     raw_cnt   [NUM_CHANNELS];
  logic [CW-1:0]     clamp_cnt [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] req, grant;
  logic [IW-1:0]     grant_idx;
  logic              grant_valid;
  logic [7:0]        seg [IN_BYTES];
  logic [CW-1:0]     seg_cnt;

  // Output word framing depends only on registered state.
  always_comb begin
    out_valid = 1'b0;
    out_bytes = OW'(OUT_BYTES);
    out_last  = 1'b0;
    case (state_q)
      RUN:     out_valid = (fill_q >= FW'(OUT_BYTES));
      FLUSH:   out_valid = (fill_q > FW'(OUT_BYTES));
      LAST: begin
        out_valid = 1'b1;
        out_bytes = OW'(fill_q);
        out_last  = 1'b1;
      end
      default: out_valid = 1'b0;
    endcase
  end

  assign dataOutValid = reset && out_valid;
  assign dataOutLast  = reset && out_last;
  assign dataOutBytes = reset ? out_bytes : '0;
  assign busy         = reset && ((fill_q != '0) || (state_q != RUN));

  always_comb begin
    dataOut = '0;
    for (int b = 0; b < OUT_BYTES; b++) begin
      if (reset && (OW'(b) < out_bytes)) dataOut[b*8 +: 8] = buf_q[b];
    end
  end

  assign pop        = dataOutValid && dataOutReady;
  assign pop_bytes  = pop ? FW'(out_bytes) : '0;
  assign fill_after = fill_q - pop_bytes;
  assign free_after = FW'(BUF_BYTES) - fill_after;

  assign grant_allowed = reset && (state_q == RUN) && !endOfStream;

  // Eligibility uses the free space left after this cycle's pop.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      raw_cnt[c]   = inByteCount[c*CW +: CW];
      clamp_cnt[c] = (raw_cnt[c] > CW'(IN_BYTES)) ? CW'(IN_BYTES) : raw_cnt[c];
      req[c]       = grant_allowed && (raw_cnt[c] != '0) &&
                     (FW'(clamp_cnt[c]) <= free_after);
    end
  end

  rr_arbiter #(
    .N  (NUM_CHANNELS),
    .IW (IW)
  ) u_arbiter (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign inTaken = grant;

  always_comb begin
    seg_cnt = '0;
    for (int j = 0; j < IN_BYTES; j++) seg[j] = 8'h00;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant[c]) begin
        seg_cnt = clamp_cnt[c];
        for (int j = 0; j < IN_BYTES; j++) seg[j] = inData[(c*IN_BYTES + j)*8 +: 8];
      end
    end
  end

  // Head-aligned shift by the popped amount, then the granted segment lands
  // at the post-pop tail; vacated slots refill with zero.
  always_comb begin
    for (int i = 0; i < BUF_BYTES; i++) begin
      buf_d[i] = 8'h00;
      for (int k = 0; (k <= OUT_BYTES) && (i + k < BUF_BYTES); k++) begin
        if (pop_bytes == FW'(k)) buf_d[i] = buf_q[i + k];
      end
      for (int j = 0; (j < IN_BYTES) && (j <= i); j++) begin
        if ((CW'(j) < seg_cnt) && (fill_after == FW'(i - j))) buf_d[i] = seg[j];
      end
    end
  end

  assign fill_d = fill_after + FW'(seg_cnt);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (endOfStream) state_d = FLUSH;
      FLUSH:   if (fill_after <= FW'(OUT_BYTES)) state_d = LAST;
      LAST:    if (pop) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      fill_q       <= '0;
      last_grant_q <= IW'(NUM_CHANNELS - 1);
      buf_q        <= '{default: 8'h00};
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      if (grant_valid) last_grant_q <= grant_idx;
    end
  end

endmodule
